n64_poll_scheduler: RTL and testbench

- Sequences the N64 serial interface: issues periodic poll requests (polling_enable), runs controller reset pulses, and supervises each transaction through the interface's write_module_active busy line.
- Latches each completed 32-bit button sample and flags stalled transactions with a timeout error.
- Sits between the APB register interface (enable, period and reset-request controls) and the n64 serial interface.

---
 rtl/n64_poll_scheduler.sv | 156 +++++++++++++++
 tb/tb_n64_poll_scheduler.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_poll_scheduler.sv
// n64_poll_scheduler: paces N64 controller polls, supervises each serial
// transaction through the interface busy line, latches completed samples,
// and recovers from stalled transactions with a controller reset sequence.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | polling stopped; waits for enable or reset_req
// RST   | controller_reset held high for RESET_CYCLES cycles
// WAIT  | counting down the poll spacing P
// REQ   | one-cycle polling_enable pulse, arms the ACK timeout
// ACK   | waiting for busy to rise
// BUSY  | waiting for busy to fall
// LATCH | sample captured, poll_count bumped, timeout_err cleared
// ERR   | ACK/BUSY phase timed out; timeout_err set, then reset sequence
module n64_poll_scheduler #(
  parameter int DEFAULT_PERIOD = 1000000,
  parameter int PERIOD_W       = 24,
  parameter int RESET_CYCLES   = 64,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                PCLK,
  input  logic                reset,
  input  logic                enable,
  input  logic                reset_req,
  input  logic [PERIOD_W-1:0] period_cfg,
  input  logic                busy,
  input  logic [31:0]         button_data_in,
  output logic                polling_enable,
  output logic                controller_reset,
  output logic [31:0]         button_data,
  output logic                sample_valid,
  output logic                timeout_err,
  output logic [15:0]         poll_count
);

  // One shared down-counter serves the period, timeout and reset phases,
  // so it is sized for the widest of the three.
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RC_W  = $clog2(RESET_CYCLES + 1);
  localparam int DP_W  = $clog2(DEFAULT_PERIOD + 1);
  localparam int W_A   = (PERIOD_W > TO_W) ? PERIOD_W : TO_W;
  localparam int W_B   = (W_A > RC_W) ? W_A : RC_W;
  localparam int CNT_W = (W_B > DP_W) ? W_B : DP_W;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_LOAD = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RESET_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_WAIT, S_REQ, S_ACK, S_BUSY, S_LATCH, S_ERR
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] period_load;

  assign period_load = (period_cfg == '0) ? DEF_LOAD : CNT_W'(period_cfg);

  // State register and phase down-counter.
  always_ff @(posedge PCLK) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and counter reload/decrement; reset_req overrides everything
  // except an already running reset sequence.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (reset_req && state != S_RST) begin
      state_next = S_RST;
      cnt_next   = RST_LOAD;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            state_next = S_WAIT;
            cnt_next   = period_load;
          end
        end
        S_RST: begin
          if (cnt == CNT_ONE) state_next = S_IDLE;
          else                cnt_next   = cnt - CNT_ONE;
        end
        S_WAIT: begin
          if (!enable)             state_next = S_IDLE;
          else if (cnt == CNT_ONE) state_next = S_REQ;
          else                     cnt_next   = cnt - CNT_ONE;
        end
        S_REQ: begin
          state_next = S_ACK;
          cnt_next   = TO_LOAD;
        end
        S_ACK: begin
          if (busy) begin
            state_next = S_BUSY;
            cnt_next   = TO_LOAD;
          end else if (cnt == CNT_ONE) begin
            state_next = S_ERR;
          end else begin
            cnt_next = cnt - CNT_ONE;
          end
        end
        S_BUSY: begin
          if (!busy)               state_next = S_LATCH;
          else if (cnt == CNT_ONE) state_next = S_ERR;
          else                     cnt_next   = cnt - CNT_ONE;
        end
        S_LATCH: begin
          if (enable) begin
            state_next = S_WAIT;
            cnt_next   = period_load;
          end else begin
            state_next = S_IDLE;
          end
        end
        S_ERR: begin
          state_next = S_RST;
          cnt_next   = RST_LOAD;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Registered outputs decoded from the next state, so each pulse lines up
  // with the cycle the FSM spends in the corresponding state.
  always_ff @(posedge PCLK) begin
    if (reset) begin
      polling_enable   <= 1'b0;
      controller_reset <= 1'b0;
      sample_valid     <= 1'b0;
      timeout_err      <= 1'b0;
      button_data      <= '0;
      poll_count       <= '0;
    end else begin
      polling_enable   <= (state_next == S_REQ);
      controller_reset <= (state_next == S_RST);
      sample_valid     <= (state_next == S_LATCH);
      if (state_next == S_LATCH) begin
        button_data <= button_data_in;
        poll_count  <= poll_count + 16'd1;
        timeout_err <= 1'b0;
      end else if (state_next == S_ERR) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_n64_poll_scheduler.sv
// Testbench for n64_poll_scheduler: directed sequences, a cycle table and a
// randomized run checked against a duration-based timeline model.
module tb_n64_poll_scheduler;

  localparam int DP = 100;
  localparam int RC = 8;
  localparam int TO = 20;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        reset_req;
  logic [23:0] period_cfg;
  logic        busy;
  logic [31:0] data_in;
  logic        polling_enable;
  logic        controller_reset;
  logic [31:0] button_data;
  logic        sample_valid;
  logic        timeout_err;
  logic [15:0] poll_count;

  logic busy_drv;
  logic busy_auto;
  logic auto;
  int   ph;

  int total = 0;
  int bad   = 0;

  assign busy = auto ? busy_auto : busy_drv;

  n64_poll_scheduler #(
    .DEFAULT_PERIOD(DP),
    .PERIOD_W(24),
    .RESET_CYCLES(RC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(clk),
    .reset(reset),
    .enable(enable),
    .reset_req(reset_req),
    .period_cfg(period_cfg),
    .busy(busy),
    .button_data_in(data_in),
    .polling_enable(polling_enable),
    .controller_reset(controller_reset),
    .button_data(button_data),
    .sample_valid(sample_valid),
    .timeout_err(timeout_err),
    .poll_count(poll_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Responder: busy rises 3 cycles after polling_enable and stays 10 cycles.
  initial begin
    ph = -1;
    busy_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (polling_enable) ph = 0;
      else if (ph >= 0 && ph < 1000) ph++;
      busy_auto = (ph >= 3 && ph <= 12);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // sel: 0 polling_enable, 1 sample_valid, 2 timeout_err, 3 controller_reset
  task automatic wait_for(input int sel, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if ((sel == 0 && polling_enable) || (sel == 1 && sample_valid) ||
          (sel == 2 && timeout_err) || (sel == 3 && controller_reset)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    reset_req = 1'b0;
    busy_drv = 1'b0;
    auto = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Directed cycle table: run-length rows of inputs and expected
  // {polling_enable, controller_reset, sample_valid, timeout_err}.
  typedef struct {
    int          n;
    logic        en;
    logic        rr;
    logic        bz;
    logic [23:0] cfg;
    logic [3:0]  exp;
  } vec_t;

  vec_t vt[21];

  // Timeline model record: inputs for one cycle and the outputs expected then.
  typedef struct {
    logic        en;
    logic        rr;
    logic        bz;
    logic [23:0] cfg;
    logic [31:0] din;
    logic        pe;
    logic        cr;
    logic        sv;
    logic        er;
    logic [31:0] data;
    logic [15:0] cnt;
  } cyc_t;

  cyc_t        tl[$];
  logic        m_err;
  logic [31:0] m_data;
  logic [15:0] m_cnt;
  int          b_k;
  int          b_inj;
  bit          b_ab;
  logic [23:0] b_cfg;
  logic [31:0] b_d;

  task automatic add(input logic bz, input logic pe, input logic cr, input logic sv, input logic rx);
    cyc_t r;
    if (b_ab) return;
    r.en = 1'b1;
    r.rr = (b_k == b_inj) | rx;
    r.bz = bz;
    r.cfg = b_cfg;
    r.din = b_d;
    r.pe = pe;
    r.cr = cr;
    r.sv = sv;
    r.er = m_err;
    r.data = m_data;
    r.cnt = m_cnt;
    tl.push_back(r);
    if (b_k == b_inj) b_ab = 1'b1;
    b_k++;
  endtask

  // One poll described by durations: P wait cycles, REQ, a-cycle ACK,
  // b-cycle busy window, then LATCH, or ERR plus the reset sequence.
  task automatic build_txn(input logic [23:0] cfg, input int a, input int b, input int inj, input logic [31:0] d);
    int   p;
    bit   erred;
    cyc_t r;
    p = (cfg == 24'd0) ? DP : int'(cfg);
    r = tl[tl.size()-1];
    r.cfg = cfg;
    tl[tl.size()-1] = r;
    b_cfg = cfg;
    b_d = d;
    b_inj = inj;
    b_k = 0;
    b_ab = 1'b0;
    erred = 1'b0;
    repeat (p) add(0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0);
    if (a > TO) begin
      repeat (TO) add(0, 0, 0, 0, 0);
      if (!b_ab) m_err = 1'b1;
      add(0, 0, 0, 0, 0);
      erred = 1'b1;
    end else begin
      repeat (a - 1) add(0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0);
      if (b > TO) begin
        repeat (TO) add(1, 0, 0, 0, 0);
        if (!b_ab) m_err = 1'b1;
        add(0, 0, 0, 0, 0);
        erred = 1'b1;
      end else begin
        repeat (b - 1) add(1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0);
        if (!b_ab) begin
          m_data = d;
          m_cnt = m_cnt + 16'd1;
          m_err = 1'b0;
        end
        add(0, 0, 0, 1, 0);
      end
    end
    if (b_ab || erred) begin
      b_inj = -1;
      b_ab = 1'b0;
      for (int i = 0; i < RC; i++) add(0, 0, 1, 0, $urandom_range(0, 3) == 0);
      add(0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    int          n;
    int          len;
    int          a;
    int          b;
    int          p;
    int          inj;
    logic [23:0] cfg;
    logic [31:0] x;

    reset = 1'b1;
    enable = 1'b0;
    reset_req = 1'b0;
    period_cfg = 24'd0;
    busy_drv = 1'b0;
    auto = 1'b0;
    data_in = 32'd0;

    // Normal poll with the default period
    reset_dut();
    chk("reset_outs", {polling_enable, controller_reset, sample_valid, timeout_err, poll_count, button_data}, 52'd0);
    period_cfg = 24'd0;
    enable = 1'b1;
    auto = 1'b1;
    data_in = 32'hA5A5_0F0F;
    wait_for(0, 300, n);
    chk("t1_first_pe", n, 101);
    wait_for(1, 40, n);
    chk("t1_sv_delay", n, 14);
    chk("t1_data", button_data, 32'hA5A5_0F0F);
    chk("t1_count", poll_count, 16'd1);
    chk("t1_err", timeout_err, 1'b0);
    wait_for(0, 300, n);
    chk("t1_repeat_pe", n, 101);

    // Table: configured period, reset_req in BUSY, ignored reset_req in RST,
    // enable drop in WAIT
    vt[0]  = '{1, 1, 0, 0, 24'd5, 4'b0000};
    vt[1]  = '{5, 1, 0, 0, 24'd5, 4'b0000};
    vt[2]  = '{1, 1, 0, 0, 24'd5, 4'b1000};
    vt[3]  = '{2, 1, 0, 0, 24'd5, 4'b0000};
    vt[4]  = '{1, 1, 0, 1, 24'd5, 4'b0000};
    vt[5]  = '{9, 1, 0, 1, 24'd5, 4'b0000};
    vt[6]  = '{1, 1, 0, 0, 24'd5, 4'b0000};
    vt[7]  = '{1, 1, 0, 0, 24'd5, 4'b0010};
    vt[8]  = '{5, 1, 0, 0, 24'd5, 4'b0000};
    vt[9]  = '{1, 1, 0, 0, 24'd5, 4'b1000};
    vt[10] = '{2, 1, 0, 0, 24'd5, 4'b0000};
    vt[11] = '{1, 1, 0, 1, 24'd5, 4'b0000};
    vt[12] = '{2, 1, 0, 1, 24'd5, 4'b0000};
    vt[13] = '{1, 1, 1, 1, 24'd5, 4'b0000};
    vt[14] = '{3, 1, 0, 0, 24'd5, 4'b0100};
    vt[15] = '{1, 1, 1, 0, 24'd5, 4'b0100};
    vt[16] = '{4, 1, 0, 0, 24'd5, 4'b0100};
    vt[17] = '{1, 1, 0, 0, 24'd5, 4'b0000};
    vt[18] = '{2, 1, 0, 0, 24'd5, 4'b0000};
    vt[19] = '{1, 0, 0, 0, 24'd5, 4'b0000};
    vt[20] = '{12, 0, 0, 0, 24'd5, 4'b0000};
    reset_dut();
    data_in = 32'h0BAD_C0DE;
    for (int r = 0; r < 21; r++) begin
      for (int c = 0; c < vt[r].n; c++) begin
        chk($sformatf("tbl_r%0d_c%0d", r, c), {polling_enable, controller_reset, sample_valid, timeout_err}, vt[r].exp);
        enable = vt[r].en;
        reset_req = vt[r].rr;
        busy_drv = vt[r].bz;
        period_cfg = vt[r].cfg;
        @(negedge clk);
      end
    end
    reset_req = 1'b0;
    chk("tbl_count", poll_count, 16'd1);
    chk("tbl_data", button_data, 32'h0BAD_C0DE);

    // ACK timeout, recovery, and clearing on the next good poll
    reset_dut();
    x = 32'h1357_9BDF;
    period_cfg = 24'd5;
    enable = 1'b1;
    auto = 1'b1;
    data_in = x;
    wait_for(1, 60, n);
    chk("t3_first_sv", n, 20);
    auto = 1'b0;
    busy_drv = 1'b0;
    data_in = 32'hDEAD_BEEF;
    wait_for(0, 20, n);
    chk("t3_pe", n, 6);
    wait_for(2, 40, n);
    chk("t3_err_delay", n, 21);
    chk("t3_data_hold", button_data, x);
    chk("t3_count_hold", poll_count, 16'd1);
    wait_for(3, 5, n);
    chk("t3_rst_start", n, 1);
    len = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (controller_reset) len++;
      else break;
    end
    chk("t3_rst_len", len, RC);
    auto = 1'b1;
    data_in = 32'hCAFE_F00D;
    wait_for(0, 20, n);
    chk("t3_resume_pe", n, 6);
    chk("t3_err_sticky", timeout_err, 1'b1);
    chk("t3_data_before", button_data, x);
    wait_for(1, 20, n);
    chk("t3_sv", n, 14);
    chk("t3_err_clear", timeout_err, 1'b0);
    chk("t3_data_new", button_data, 32'hCAFE_F00D);
    chk("t3_count", poll_count, 16'd2);

    // poll_count wrap
    reset_dut();
    period_cfg = 24'd3;
    enable = 1'b1;
    auto = 1'b1;
    data_in = 32'h0000_1111;
    wait_for(0, 20, n);
    chk("t5_pe", n, 4);
    force dut.poll_count = 16'hFFFF;
    @(negedge clk);
    release dut.poll_count;
    wait_for(1, 30, n);
    chk("t5_sv", n, 13);
    chk("t5_wrap", poll_count, 16'h0000);

    // Synchronous reset during BUSY
    reset_dut();
    period_cfg = 24'd4;
    enable = 1'b1;
    auto = 1'b1;
    data_in = 32'h55AA_55AA;
    wait_for(1, 40, n);
    chk("t6_first_sv", n, 19);
    wait_for(0, 20, n);
    chk("t6_pe", n, 5);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_reset_outs", {polling_enable, controller_reset, sample_valid, timeout_err, poll_count, button_data}, 52'd0);
    wait_for(0, 20, n);
    chk("t6_idle_then_wait", n, 5);

    // Randomized transactions against the timeline model
    reset_dut();
    tl.delete();
    m_err = 1'b0;
    m_data = 32'd0;
    m_cnt = 16'd0;
    b_inj = -1;
    b_ab = 1'b0;
    b_k = 0;
    b_cfg = 24'd0;
    b_d = 32'd0;
    add(0, 0, 0, 0, 0);
    for (int t = 0; t < 30; t++) begin
      cfg = ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom_range(1, 8));
      a = ($urandom_range(0, 5) == 0) ? int'($urandom_range(21, 24)) : int'($urandom_range(1, 6));
      b = ($urandom_range(0, 5) == 0) ? int'($urandom_range(21, 23)) : int'($urandom_range(1, 12));
      p = (cfg == 24'd0) ? DP : int'(cfg);
      len = p + 1 + ((a <= TO) ? (a + ((b <= TO) ? b + 1 : TO + 1)) : TO + 1);
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      build_txn(cfg, a, b, inj, $urandom);
    end
    for (int i = 0; i < tl.size(); i++) begin
      chk($sformatf("rand_c%0d", i),
          {polling_enable, controller_reset, sample_valid, timeout_err, poll_count, button_data},
          {tl[i].pe, tl[i].cr, tl[i].sv, tl[i].er, tl[i].cnt, tl[i].data});
      enable = tl[i].en;
      reset_req = tl[i].rr;
      busy_drv = tl[i].bz;
      period_cfg = tl[i].cfg;
      data_in = tl[i].din;
      @(negedge clk);
    end
    reset_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
